// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes, bit-field positions and
// packed register layouts shared by the P7 coprocessor-0 files.
// Build option: CP0_PRID_EN enables the read-only PRId register (15).
package cp0_pkg;

  // CP0 register numbers seen by mtc0/mfc0
  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // Exception handler entry point fetched when req is raised
  localparam logic [31:0] CP0_HANDLER_ADDR = 32'h0000_4180;

  // Processor identification constant (only visible with CP0_PRID_EN)
  localparam logic [31:0] CP0_PRID_VALUE = 32'h0050_0701;

  // Bit-field positions inside SR and Cause
  localparam int SR_IM_HI     = 15;
  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IE_BIT    = 0;
  localparam int CAUSE_BD_BIT = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  // Implemented SR state
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  // Implemented Cause state
  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  // Place SR fields at their architectural bit positions; the rest read 0
  function automatic logic [31:0] sr_to_word(input sr_t sr);
    logic [31:0] w;
    w = 32'd0;
    w[SR_IM_HI:SR_IM_LO] = sr.im;
    w[SR_EXL_BIT]        = sr.exl;
    w[SR_IE_BIT]         = sr.ie;
    return w;
  endfunction

  // Place Cause fields at their architectural bit positions; the rest read 0
  function automatic logic [31:0] cause_to_word(input cause_t c);
    logic [31:0] w;
    w = 32'd0;
    w[CAUSE_BD_BIT]              = c.bd;
    w[CAUSE_IP_HI:CAUSE_IP_LO]   = c.ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO] = c.exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// cp0_req_arb: combinational arbitration of masked hardware interrupts
// against the pipeline exception code. Interrupts win, so the code to be
// latched into Cause is INT whenever an interrupt is taken.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_in,
  output logic       req,
  output logic       int_req,
  output logic [4:0] exc_code_out
);

  logic exc_req;

  // Both request sources are blocked while a handler is running (EXL)
  always_comb begin
    int_req      = (|(hw_int & im)) & ie & ~exl;
    exc_req      = (exc_code_in != EXC_INT) & ~exl;
    req          = int_req | exc_req;
    exc_code_out = int_req ? EXC_INT : exc_code_in;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor 0 for the P7 pipelined MIPS core (M stage).
// Holds SR, Cause and EPC, raises req to redirect fetch to the handler,
// and supplies epc_out (with same-cycle mtc0 bypass) for eret.
// Build option: CP0_PRID_EN implements read-only PRId at register 15.
module cp0_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out
);

  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic [4:0]  arb_exc_code;
  logic        unused_int_req;

  cp0_req_arb u_arb (
    .hw_int       (hw_int),
    .im           (sr_q.im),
    .ie           (sr_q.ie),
    .exl          (sr_q.exl),
    .exc_code_in  (exc_code_in),
    .req          (req),
    .int_req      (int_req),
    .exc_code_out (arb_exc_code)
  );

  // The arbiter already folds interrupt priority into arb_exc_code
  assign unused_int_req = int_req;

  // Next-state: req beats mtc0 and exl_clr; exl_clr beats the SR EXL bit
  always_comb begin
    sr_d        = sr_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    cause_d.ip  = hw_int;
    if (req) begin
      sr_d.exl         = 1'b1;
      cause_d.bd       = bd_in;
      cause_d.exc_code = arb_exc_code;
      epc_d            = bd_in ? (vpc - 32'd4) : vpc;
    end else begin
      if (we && addr == CP0_REG_SR) begin
        sr_d.im  = wdata[SR_IM_HI:SR_IM_LO];
        sr_d.exl = wdata[SR_EXL_BIT];
        sr_d.ie  = wdata[SR_IE_BIT];
      end
      if (we && addr == CP0_REG_EPC) begin
        epc_d = wdata;
      end
      if (exl_clr) begin
        sr_d.exl = 1'b0;
      end
    end
  end

  // State registers with synchronous reset to all-zero
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read mux; unimplemented registers read as zero
  always_comb begin
    rdata = 32'd0;
    case (addr)
      CP0_REG_SR:    rdata = sr_to_word(sr_q);
      CP0_REG_CAUSE: rdata = cause_to_word(cause_q);
      CP0_REG_EPC:   rdata = epc_q;
`ifdef CP0_PRID_EN
      CP0_REG_PRID:  rdata = CP0_PRID_VALUE;
`endif
      default:       rdata = 32'd0;
    endcase
  end

  // Return PC with same-cycle mtc0 EPC bypass, unless req discards the write
  always_comb begin
    epc_out = epc_q;
    if (we && addr == CP0_REG_EPC && !req) begin
      epc_out = wdata;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: table-driven check of cp0_ctrl. Each table row is one clock
// cycle: inputs are driven after the falling edge, combinational outputs
// are compared shortly after, and the rising edge then commits state.
module tb_cp0_ctrl;
  import cp0_pkg::*;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;

  cp0_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .exl_clr     (exl_clr),
    .req         (req),
    .epc_out     (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        exp_req;
    logic [31:0] exp_rdata;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic w, input logic [4:0] a,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic bd, input logic [4:0] exc,
                              input logic [5:0] hw, input logic clr,
                              input logic er, input logic [31:0] erd,
                              input logic [31:0] eepc);
    vec_t v;
    v.rst = rst; v.we = w; v.addr = a; v.wdata = wd; v.vpc = pc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.clr = clr;
    v.exp_req = er; v.exp_rdata = erd; v.exp_epc = eepc;
    vecs.push_back(v);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic [4:0] a,
                       input logic [31:0] wd, input logic [31:0] pc, input logic bd,
                       input logic [4:0] exc, input logic [5:0] hw, input logic clr);
    @(negedge clk);
    reset = rst; we = w; addr = a; wdata = wd; vpc = pc; bd_in = bd;
    exc_code_in = exc; hw_int = hw; exl_clr = clr;
    #2;
  endtask

  task automatic apply(input int idx, input vec_t v);
    drive(v.rst, v.we, v.addr, v.wdata, v.vpc, v.bd, v.exc, v.hw, v.clr);
    check32($sformatf("row%0d.req", idx), {31'd0, req}, {31'd0, v.exp_req});
    check32($sformatf("row%0d.rdata", idx), rdata, v.exp_rdata);
    check32($sformatf("row%0d.epc_out", idx), epc_out, v.exp_epc);
    $display("row %0d: we=%0b addr=%0d hw=%02h exc=%0d clr=%0b -> req=%0b rdata=%08h epc_out=%08h",
             idx, v.we, v.addr, v.hw, v.exc, v.clr, req, rdata, epc_out);
  endtask

  logic [31:0] prid_exp;

  initial begin
`ifdef CP0_PRID_EN
    prid_exp = CP0_PRID_VALUE;
`else
    prid_exp = 32'd0;
`endif
    reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'd0; vpc = 32'd0;
    bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; exl_clr = 1'b0;
    repeat (2) @(posedge clk);

    //   rst we addr wdata          vpc            bd exc hw     clr req rdata          epc_out
    add(0, 0, 12, 32'h0,          32'h0,         0, 0,  6'h00, 0, 0, 32'h0,          32'h0);        // 0 SR after reset
    add(0, 0, 13, 32'h0,          32'h0,         0, 0,  6'h00, 0, 0, 32'h0,          32'h0);        // 1 Cause after reset
    add(0, 0, 14, 32'h0,          32'h0,         0, 0,  6'h3F, 0, 0, 32'h0,          32'h0);        // 2 EPC, req=0 with IE=0
    add(0, 0, 13, 32'h0,          32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_FC00,  32'h0);        // 3 IP tracks hw_int
    add(0, 1, 12, 32'h0000_0401,  32'h0,         0, 0,  6'h00, 0, 0, 32'h0,          32'h0);        // 4 mtc0 SR
    add(0, 0, 12, 32'h0,          32'h0000_1000, 0, 0,  6'h01, 0, 1, 32'h0000_0401,  32'h0);        // 5 interrupt
    add(0, 0, 13, 32'h0,          32'h0,         0, 0,  6'h01, 0, 0, 32'h0000_0400,  32'h0000_1000);// 6 Cause after int
    add(0, 0, 12, 32'h0,          32'h0,         0, 0,  6'h01, 0, 0, 32'h0000_0403,  32'h0000_1000);// 7 EXL set, req held off
    add(0, 0, 12, 32'h0,          32'h0,         0, 0,  6'h00, 1, 0, 32'h0000_0403,  32'h0000_1000);// 8 eret
    add(0, 0, 12, 32'h0,          32'h0000_3010, 1, 12, 6'h00, 0, 1, 32'h0000_0401,  32'h0000_1000);// 9 Ov in delay slot
    add(0, 0, 13, 32'h0,          32'h0,         0, 0,  6'h00, 0, 0, 32'h8000_0030,  32'h0000_300C);// 10 BD, code 12
    add(0, 0, 14, 32'h0,          32'h0,         0, 5,  6'h00, 0, 0, 32'h0000_300C,  32'h0000_300C);// 11 exc ignored under EXL
    add(0, 1, 12, 32'h0000_0403,  32'h0,         0, 0,  6'h00, 1, 0, 32'h0000_0403,  32'h0000_300C);// 12 SR write + exl_clr
    add(0, 0, 12, 32'h0,          32'h0000_2000, 0, 10, 6'h01, 0, 1, 32'h0000_0401,  32'h0000_300C);// 13 int beats RI
    add(0, 0, 13, 32'h0,          32'h0,         0, 0,  6'h01, 0, 0, 32'h0000_0400,  32'h0000_2000);// 14 ExcCode 0
    add(0, 0, 12, 32'h0,          32'h0,         0, 0,  6'h01, 1, 0, 32'h0000_0403,  32'h0000_2000);// 15 eret, line held
    add(0, 0, 12, 32'h0,          32'h0000_2004, 0, 0,  6'h01, 0, 1, 32'h0000_0401,  32'h0000_2000);// 16 req re-raised
    add(0, 1, 14, 32'h0000_3100,  32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_2004,  32'h0000_3100);// 17 EPC bypass
    add(0, 0, 14, 32'h0,          32'h0,         0, 0,  6'h00, 1, 0, 32'h0000_3100,  32'h0000_3100);// 18 EPC written
    add(0, 1, 12, 32'h5555_0000,  32'h0000_4000, 1, 0,  6'h01, 0, 1, 32'h0000_0401,  32'h0000_3100);// 19 SR write vs req
    add(0, 0, 14, 32'h0,          32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_3FFC,  32'h0000_3FFC);// 20 EPC = vpc-4
    add(0, 0, 12, 32'h0,          32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_0403,  32'h0000_3FFC);// 21 SR write discarded
    add(0, 1, 13, 32'hFFFF_FFFF,  32'h0,         0, 0,  6'h00, 0, 0, 32'h8000_0000,  32'h0000_3FFC);// 22 Cause write
    add(0, 0, 13, 32'h0,          32'h0,         0, 0,  6'h00, 0, 0, 32'h8000_0000,  32'h0000_3FFC);// 23 Cause unchanged
    add(0, 1, 3,  32'hFFFF_FFFF,  32'h0,         0, 0,  6'h00, 0, 0, 32'h0,          32'h0000_3FFC);// 24 unimplemented
    add(0, 1, 12, 32'h0,          32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_0403,  32'h0000_3FFC);// 25 SR cleared
    add(0, 0, 12, 32'h0,          32'h0,         0, 0,  6'h3F, 0, 0, 32'h0,          32'h0000_3FFC);// 26 IE=0 masks

    foreach (vecs[i]) apply(i, vecs[i]);

    // PRId or unimplemented register 15, write ignored
    drive(0, 1, 15, 32'hDEAD_BEEF, 32'h0, 0, 0, 6'h00, 0);
    drive(0, 0, 15, 32'h0, 32'h0, 0, 0, 6'h00, 0);
    check32("prid.rdata", rdata, prid_exp);
    $display("seq prid: rdata=%08h", rdata);

    // vpc = 0 in a delay slot wraps; same-cycle mtc0 SR is discarded
    drive(0, 1, 12, 32'h0000_FC03, 32'h0, 1, EXC_ADEL, 6'h00, 0);
    check32("wrap.req", {31'd0, req}, 32'd1);
    drive(0, 0, 14, 32'h0, 32'h0, 0, 0, 6'h00, 0);
    check32("wrap.epc", rdata, 32'hFFFF_FFFC);
    check32("wrap.epc_out", epc_out, 32'hFFFF_FFFC);
    drive(0, 0, 12, 32'h0, 32'h0, 0, 0, 6'h00, 0);
    check32("wrap.sr", rdata, 32'h0000_0002);
    drive(0, 0, 13, 32'h0, 32'h0, 0, 0, 6'h00, 0);
    check32("wrap.cause", rdata, 32'h8000_0010);
    $display("seq wrap: cause=%08h epc_out=%08h", rdata, epc_out);

    // req and exl_clr together: EXL stays set
    drive(0, 1, 12, 32'h0, 32'h0, 0, 0, 6'h00, 0);
    drive(0, 0, 12, 32'h0, 32'h0000_0100, 0, EXC_SYSCALL, 6'h00, 1);
    check32("reqclr.req", {31'd0, req}, 32'd1);
    drive(0, 0, 12, 32'h0, 32'h0, 0, 0, 6'h00, 0);
    check32("reqclr.sr", rdata, 32'h0000_0002);
    drive(0, 0, 13, 32'h0, 32'h0, 0, 0, 6'h00, 0);
    check32("reqclr.cause", rdata, 32'h0000_0020);
    $display("seq req+exl_clr: cause=%08h", rdata);

    // Reset mid-handler clears everything; reset beats a concurrent req source
    drive(0, 1, 12, 32'h0000_0401, 32'h0, 0, 0, 6'h00, 1);
    drive(0, 0, 12, 32'h0, 32'h0000_0500, 0, 0, 6'h01, 0);
    check32("rst.req_before", {31'd0, req}, 32'd1);
    drive(1, 1, 14, 32'h0000_7777, 32'h0, 0, 0, 6'h3F, 0);
    drive(0, 0, 12, 32'h0, 32'h0, 0, 0, 6'h3F, 0);
    check32("rst.sr", rdata, 32'h0);
    check32("rst.req", {31'd0, req}, 32'd0);
    check32("rst.epc_out", epc_out, 32'h0);
    $display("seq reset: sr=%08h req=%0b epc_out=%08h", rdata, req, epc_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
